updown_counter_gen: RTL
=======================

Name: updown_counter_gen

Overview:
- Parametrised successor to the 3-bit up/down counter: WIDTH-bit loadable counter with a programmable upper limit.
- Four selectable modes: wrap, saturate, ping-pong and one-shot.
- Registered terminal-count pulse, plus status flags for zero, top, direction and done.
- Instantiated behind the tt_um top level (ui_in/uio_in control, uo_out count) or reused as a timer/prescaler inside larger designs.

Parameters:
- WIDTH, 8, counter and limit width in bits; legal range 2..16.
- RST_LIMIT, 2**WIDTH-1, value of the internal limit register after reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- cnt_en  input  1  count enable; one step per cycle while high
- up_dn  input  1  1 = count up, 0 = count down (direction source; see ping-pong/one-shot)
- ld  input  1  synchronous load of ld_data into count
- ld_data  input  WIDTH  load value
- lim_we  input  1  write ld_data into the limit register
- mode  input  2  00 wrap, 01 saturate, 10 ping-pong, 11 one-shot
- count  output  WIDTH  current count (register)
- limit  output  WIDTH  current limit register
- tc  output  1  one-cycle terminal-count pulse (register)
- at_zero  output  1  count == 0
- at_top  output  1  count >= limit
- dir  output  1  effective direction register, 1 = up
- done  output  1  one-shot finished (register)

Behaviour:
- Reset (async assert, sync release by upstream): count=0, limit=RST_LIMIT, tc=0, dir=1, done=0, one-shot FSM=IDLE.
- Reset mid-operation clears all state immediately, with no wait for clk.
- Legal range is 0..limit. "top" means count >= limit; "bottom" means count == 0.
- Priority per cycle: lim_we and ld may coincide.
  - On coincidence, the new limit applies to the same load's clamp.
  - ld beats cnt_en.
  - ld_data > effective limit loads the limit value.
- ld: count <= clamp(ld_data); dir <= up_dn; done <= 0; tc <= 0; FSM <= RUN when mode=11.
- Count step (cnt_en=1, no ld), latency 1 cycle. tc asserts in the same cycle the new count appears, for exactly one cycle.
- Wrap (00), direction = up_dn each cycle:
  - up at top -> 0, tc=1.
  - down at 0 -> limit, tc=1.
  - otherwise +/-1.
- Saturate (01), direction = up_dn:
  - up at top -> count <= limit, with tc=1 only on the step that first reaches limit.
  - down at 0 -> holds 0, with tc=1 only on the step that reaches 0.
  - No tc while already pinned.
- Ping-pong (10), up_dn ignored except on ld:
  - dir=1 and count+1 reaches or exceeds limit -> count <= limit, dir <= 0, tc=1.
  - dir=0 and count-1 reaches 0 -> count <= 0, dir <= 1, tc=1.
  - limit=0 -> count holds 0, tc every enabled cycle.
- One-shot (11), FSM IDLE -> RUN -> DONE:
  - IDLE: counting inhibited; ld -> RUN.
  - RUN: step in dir (latched at ld). A step reaching limit (up) or 0 (down) -> DONE, done=1, tc=1.
  - DONE: count frozen, cnt_en ignored; ld -> RUN, done <= 0.
  - ld with ld_data already at the terminal value -> RUN; the next enabled step then terminates without moving.
- mode change takes effect on the next cycle. Leaving 11 forces FSM IDLE and done <= 0. Entering 11 starts in IDLE.
- lim_we lowering limit below count: next enabled up-step treats the counter as at top.
  - wrap -> 0
  - saturate -> limit
  - ping-pong -> limit and reverse
  - Down-steps decrement normally.
- dir in modes 00/01 follows the registered up_dn of the last enabled step or load.
- All arithmetic is unsigned WIDTH-bit; no internal overflow beyond the limit compare.

Decomposition:
- Package updown_pkg:
  - mode_e enum (MODE_WRAP, MODE_SAT, MODE_PONG, MODE_ONESHOT).
  - os_state_e enum (OS_IDLE, OS_RUN, OS_DONE).
  - Width-checking constant function.
- Sub-module updown_step: combinational. Takes count, limit, dir, mode and produces next_count, next_dir, hit_terminal.
- Top-level updown_counter_gen holds the registers, the one-shot FSM, load/priority logic and the tc pulse.

Test Plan:
- Reset: rst_n low asynchronously mid-count at count=0x37 -> count=0, limit=0xFF, dir=1, done=0, tc=0 before next clk edge.
- Wrap, WIDTH=8: limit=5, up, cnt_en for 8 cycles from 0 -> 1,2,3,4,5,0,1,2, tc high only with the 0. Then down from 0 -> 5 with tc.
- Saturate: limit=10, load 8, up 4 cycles -> 9,10,10,10, tc only on the cycle count becomes 10. Down from 1 -> 0,0, tc once.
- Ping-pong: limit=3, load 0, up_dn=1, 8 steps -> 1,2,3,2,1,0,1,2, tc with 3 and 0. Toggling up_dn meanwhile has no effect.
- One-shot: limit=4, ld 1 with up, 5 enabled cycles -> 2,3,4,4,4, done=1 and tc on reaching 4. Re-ld 0 -> done=0, counting resumes.
- Corners:
  - ld+cnt_en same cycle -> load wins.
  - ld_data=9 with limit=6 -> count=6.
  - lim_we to 2 while count=7 in wrap, then up step -> 0 with tc.

Source files
------------

// File: rtl/updown_pkg.sv
// ----------------------------------------------------------------------------
// updown_pkg
// Shared types and helpers for the generic up/down counter.
//   mode_e     : counting mode selected by the 2-bit mode input
//   os_state_e : one-shot sequencer states
//   width_ok() : legal-width check used at elaboration time
// ----------------------------------------------------------------------------
package updown_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_PONG    = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        OS_IDLE = 2'b00,
        OS_RUN  = 2'b01,
        OS_DONE = 2'b10
    } os_state_e;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;

    // True when the counter width lies inside the supported range.
    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/updown_step.sv
// ----------------------------------------------------------------------------
// updown_step
// Combinational single-step calculator for the counter.
//   count_i        : current count
//   limit_i        : upper limit of the legal range 0..limit
//   dir_i          : direction of this step, 1 = up
//   mode_i         : counting mode
//   nextCount_o    : count after one enabled step
//   nextDir_o      : direction after the step (only ping-pong reverses it)
//   hitTerminal_o  : step produced a terminal-count event
// ----------------------------------------------------------------------------
module updown_step
    import updown_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             dir_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] nextCount_o,
    output logic             nextDir_o,
    output logic             hitTerminal_o
);

    logic             atTop;
    logic             atBottom;
    logic [WIDTH-1:0] countInc;
    logic [WIDTH-1:0] countDec;
    logic [WIDTH-1:0] limitDec;

    // A count above the limit (limit lowered under it) is treated as "at top",
    // so every up-step saturates/wraps from there instead of running on.
    assign atTop    = (count_i >= limit_i);
    assign atBottom = (count_i == '0);
    assign countInc = count_i + WIDTH'(1);
    assign countDec = count_i - WIDTH'(1);
    assign limitDec = limit_i - WIDTH'(1);

    // Next-count selection per mode; defaults hold the count and direction.
    always_comb begin
        nextCount_o   = count_i;
        nextDir_o     = dir_i;
        hitTerminal_o = 1'b0;
        unique case (mode_i)
            MODE_WRAP: begin
                if (dir_i) begin
                    if (atTop) begin
                        nextCount_o   = '0;
                        hitTerminal_o = 1'b1;
                    end else begin
                        nextCount_o = countInc;
                    end
                end else begin
                    if (atBottom) begin
                        nextCount_o   = limit_i;
                        hitTerminal_o = 1'b1;
                    end else begin
                        nextCount_o = countDec;
                    end
                end
            end
            // Terminal count only on the step that arrives at the rail,
            // never while already pinned there.
            MODE_SAT: begin
                if (dir_i) begin
                    if (atTop) begin
                        nextCount_o   = limit_i;
                        hitTerminal_o = (count_i != limit_i);
                    end else begin
                        nextCount_o   = countInc;
                        hitTerminal_o = (countInc == limit_i);
                    end
                end else if (!atBottom) begin
                    nextCount_o   = countDec;
                    hitTerminal_o = (count_i == WIDTH'(1));
                end
            end
            // The limit-1 compare avoids forming count+1, which could overflow.
            MODE_PONG: begin
                if (limit_i == '0) begin
                    nextCount_o   = '0;
                    hitTerminal_o = 1'b1;
                end else if (dir_i) begin
                    if (count_i >= limitDec) begin
                        nextCount_o   = limit_i;
                        nextDir_o     = 1'b0;
                        hitTerminal_o = 1'b1;
                    end else begin
                        nextCount_o = countInc;
                    end
                end else begin
                    if (count_i <= WIDTH'(1)) begin
                        nextCount_o   = '0;
                        nextDir_o     = 1'b1;
                        hitTerminal_o = 1'b1;
                    end else begin
                        nextCount_o = countDec;
                    end
                end
            end
            // Already sitting on the terminal value terminates without moving.
            MODE_ONESHOT: begin
                if (dir_i) begin
                    if (atTop) begin
                        nextCount_o   = limit_i;
                        hitTerminal_o = 1'b1;
                    end else begin
                        nextCount_o   = countInc;
                        hitTerminal_o = (countInc == limit_i);
                    end
                end else begin
                    if (atBottom) begin
                        hitTerminal_o = 1'b1;
                    end else begin
                        nextCount_o   = countDec;
                        hitTerminal_o = (count_i == WIDTH'(1));
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/updown_counter_gen.sv
// ----------------------------------------------------------------------------
// updown_counter_gen
// WIDTH-bit loadable up/down counter with programmable limit and four modes
// (wrap, saturate, ping-pong, one-shot).
//   clk, rst_n   : clock, asynchronous active-low reset
//   cnt_en_i     : count enable, one step per cycle
//   up_dn_i      : direction source, 1 = up
//   ld_i         : load ld_data_i (clamped to the limit) into the count
//   ld_data_i    : load / limit write value
//   lim_we_i     : write ld_data_i into the limit register
//   mode_i       : 00 wrap, 01 saturate, 10 ping-pong, 11 one-shot
//   count_o      : current count
//   limit_o      : current limit
//   tc_o         : one-cycle terminal-count pulse
//   at_zero_o    : count == 0
//   at_top_o     : count >= limit
//   dir_o        : effective direction, 1 = up
//   done_o       : one-shot finished
// ----------------------------------------------------------------------------
module updown_counter_gen
    import updown_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RST_LIMIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_en_i,
    input  logic             up_dn_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] ld_data_i,
    input  logic             lim_we_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] limit_o,
    output logic             tc_o,
    output logic             at_zero_o,
    output logic             at_top_o,
    output logic             dir_o,
    output logic             done_o
);

    if (!width_ok(WIDTH)) begin : gBadWidth
        $error("updown_counter_gen: WIDTH must lie in 2..16");
    end

    mode_e            modeSel;
    os_state_e        os_q, os_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic             stepDir;
    logic [WIDTH-1:0] stepCount;
    logic             stepNextDir;
    logic             stepHit;

    assign modeSel = mode_e'(mode_i);

    // Wrap and saturate take their direction live from up_dn; ping-pong and
    // one-shot run in the registered direction captured at load.
    assign stepDir = ((modeSel == MODE_WRAP) || (modeSel == MODE_SAT)) ? up_dn_i : dir_q;

    updown_step #(
        .WIDTH (WIDTH)
    ) uStep (
        .count_i       (count_q),
        .limit_i       (limit_q),
        .dir_i         (stepDir),
        .mode_i        (modeSel),
        .nextCount_o   (stepCount),
        .nextDir_o     (stepNextDir),
        .hitTerminal_o (stepHit)
    );

    // Next-state logic: limit write, then load (with the freshly written
    // limit as clamp), then counting. Outside one-shot the sequencer is
    // parked in IDLE so entering one-shot always starts idle.
    always_comb begin
        limit_d = lim_we_i ? ld_data_i : limit_q;
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        os_d    = os_q;

        if (modeSel != MODE_ONESHOT) begin
            os_d   = OS_IDLE;
            done_d = 1'b0;
        end

        if (ld_i) begin
            count_d = (ld_data_i > limit_d) ? limit_d : ld_data_i;
            dir_d   = up_dn_i;
            done_d  = 1'b0;
            if (modeSel == MODE_ONESHOT) begin
                os_d = OS_RUN;
            end
        end else if (cnt_en_i) begin
            if (modeSel != MODE_ONESHOT) begin
                count_d = stepCount;
                dir_d   = stepNextDir;
                tc_d    = stepHit;
            end else if (os_q == OS_RUN) begin
                count_d = stepCount;
                if (stepHit) begin
                    os_d   = OS_DONE;
                    done_d = 1'b1;
                    tc_d   = 1'b1;
                end
            end
        end
    end

    // State registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            limit_q <= RST_LIMIT;
            dir_q   <= 1'b1;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            os_q    <= OS_IDLE;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            os_q    <= os_d;
        end
    end

    assign count_o   = count_q;
    assign limit_o   = limit_q;
    assign tc_o      = tc_q;
    assign dir_o     = dir_q;
    assign done_o    = done_q;
    assign at_zero_o = (count_q == '0);
    assign at_top_o  = (count_q >= limit_q);

endmodule
